// File: rtl/sr_pkg.sv
// Shared definitions for the SR flag arbiter: command encodings, default sizes
// and a small width helper used by the interface and every module.
package sr_pkg;

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_RST  = 2'b01,
    OP_SET  = 2'b10,
    OP_ILL  = 2'b11
  } op_e;

  localparam int NREQ_DEF  = 4;
  localparam int NFLAG_DEF = 8;
  localparam int CNT_W     = 16;

  // Index width for a field that selects one of n items (never zero bits).
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Only the S=R=1 encoding is a malformed command.
  function automatic logic op_legal(input op_e o);
    return (o != OP_ILL);
  endfunction

endpackage

// File: rtl/sr_flag_arbiter_if.sv
// Request/command bus between the requesters and the flag arbiter, plus the
// flag bank and error/status outputs that the requesters observe.
interface sr_flag_arbiter_if
  import sr_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int NFLAG = NFLAG_DEF,
  parameter int IW    = $clog2(NFLAG)
);
  localparam int SW = idx_w(NREQ);

  logic [NREQ-1:0]    req;
  logic [2*NREQ-1:0]  op;
  logic [IW*NREQ-1:0] idx;
  logic               err_clr;

  logic [NREQ-1:0]    gnt;
  logic [NFLAG-1:0]   q;
  logic [NFLAG-1:0]   qbar;
  logic               err;
  logic [SW-1:0]      err_src;
  logic [CNT_W-1:0]   op_cnt;

  modport master (
    output req, op, idx, err_clr,
    input  gnt, q, qbar, err, err_src, op_cnt
  );

  modport slave (
    input  req, op, idx, err_clr,
    output gnt, q, qbar, err, err_src, op_cnt
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin pick among requesters that are asking and not currently granted;
// owns the rotating search pointer.
module rr_arbiter
  import sr_pkg::*;
#(
  parameter  int NREQ = NREQ_DEF,
  localparam int SW   = idx_w(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] mask,
  output logic            win_vld,
  output logic [SW-1:0]   win_idx
);

  logic [SW-1:0]   rr_ptr;
  logic [SW-1:0]   cand;
  logic [NREQ-1:0] elig;

  function automatic logic [SW-1:0] wrap(input int v);
    return (v >= NREQ) ? SW'(v - NREQ) : SW'(v);
  endfunction

  // A requester still showing gnt is masked so a held req is not committed twice.
  assign elig = req & ~mask;

  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = wrap(int'(rr_ptr) + k);
      if (!win_vld && elig[cand]) begin
        win_vld = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (win_vld) begin
      rr_ptr <= wrap(int'(win_idx) + 1);
    end
  end

endmodule

// File: rtl/sr_flag_arbiter.sv
// Bank of NFLAG set/reset flags shared by NREQ requesters; one winning command
// commits per clock, with a one-cycle grant, sticky error and saturating count.
module sr_flag_arbiter
  import sr_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int NFLAG = NFLAG_DEF,
  parameter int IW    = $clog2(NFLAG)
) (
  input logic              clk,
  input logic              rst_n,
  sr_flag_arbiter_if.slave bus
);

  localparam int SW = idx_w(NREQ);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             win_vld;
  logic [SW-1:0]    win_idx;
  op_e              win_op;
  logic [IW-1:0]    win_tgt;
  logic             cmd_bad;
  logic             commit;
  logic             new_err;

  logic [NREQ-1:0]  gnt;
  logic [NFLAG-1:0] q;
  logic             err;
  logic [SW-1:0]    err_src;
  logic [CNT_W-1:0] op_cnt;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (bus.req),
    .mask    (gnt),
    .win_vld (win_vld),
    .win_idx (win_idx)
  );

  // Pull the winner's command and target out of the packed per-requester buses.
  always_comb begin
    win_op  = op_e'(bus.op[2*int'(win_idx) +: 2]);
    win_tgt = bus.idx[IW*int'(win_idx) +: IW];
    cmd_bad = !op_legal(win_op) || (int'(win_tgt) >= NFLAG);
    commit  = win_vld && !cmd_bad;
    new_err = win_vld && cmd_bad;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt <= '0;
    end else begin
      gnt <= win_vld ? (NREQ'(1) << win_idx) : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (commit) begin
      for (int f = 0; f < NFLAG; f++) begin
        if (win_tgt == IW'(f)) begin
          if (win_op == OP_SET) begin
            q[f] <= 1'b1;
          end else if (win_op == OP_RST) begin
            q[f] <= 1'b0;
          end
        end
      end
    end
  end

  // A fresh error outranks a simultaneous clear; the source is latched only
  // when the sticky flag is (re)armed, so the first offender is kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err     <= 1'b0;
      err_src <= '0;
    end else if (new_err) begin
      err <= 1'b1;
      if (!err || bus.err_clr) begin
        err_src <= win_idx;
      end
    end else if (bus.err_clr) begin
      err     <= 1'b0;
      err_src <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_cnt <= '0;
    end else if (commit && (op_cnt != CNT_MAX)) begin
      op_cnt <= op_cnt + 1'b1;
    end
  end

  assign bus.gnt     = gnt;
  assign bus.q       = q;
  assign bus.qbar    = ~q;
  assign bus.err     = err;
  assign bus.err_src = err_src;
  assign bus.op_cnt  = op_cnt;

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Scoreboard bench for sr_flag_arbiter: a driver advances a behavioural model
// and queues each expected grant; a negedge monitor pops and compares.
module tb_sr_flag_arbiter;
  import sr_pkg::*;

  localparam int NREQ  = 4;
  localparam int NFLAG = 6;
  localparam int IW    = 3;
  localparam int SW    = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sr_flag_arbiter_if #(.NREQ(NREQ), .NFLAG(NFLAG), .IW(IW)) bus ();

  sr_flag_arbiter #(.NREQ(NREQ), .NFLAG(NFLAG), .IW(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [NREQ-1:0]  gnt;
    logic [NFLAG-1:0] q;
    logic             err;
    logic [SW-1:0]    src;
    logic [15:0]      cnt;
  } exp_t;

  exp_t sbq[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int               m_rr;
  logic [NFLAG-1:0] m_q;
  logic             m_err;
  int               m_src;
  int               m_cnt;
  int               m_last;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_rr = 0; m_q = '0; m_err = 1'b0; m_src = 0; m_cnt = 0; m_last = -1;
  endtask

  // Next-edge behaviour computed straight from the arbitration rules.
  task automatic model_step(input logic [NREQ-1:0] r, input logic [2*NREQ-1:0] o,
                            input logic [IW*NREQ-1:0] x, input logic ec);
    int w;
    int t;
    logic [1:0] oc;
    exp_t e;
    w = -1;
    for (int k = 0; k < NREQ; k++) begin
      int c;
      c = (m_rr + k) % NREQ;
      if (w < 0 && r[c] && c != m_last) w = c;
    end
    if (w < 0) begin
      if (ec) begin m_err = 1'b0; m_src = 0; end
      m_last = -1;
      return;
    end
    oc = o[2*w +: 2];
    t  = int'(x[IW*w +: IW]);
    if (oc == 2'b11 || t >= NFLAG) begin
      if (!m_err || ec) m_src = w;
      m_err = 1'b1;
    end else begin
      if (oc == 2'b10) m_q[t] = 1'b1;
      if (oc == 2'b01) m_q[t] = 1'b0;
      if (m_cnt < 65535) m_cnt++;
      if (ec) begin m_err = 1'b0; m_src = 0; end
    end
    m_rr   = (w + 1) % NREQ;
    m_last = w;
    e.gnt = NREQ'(1) << w;
    e.q   = m_q;
    e.err = m_err;
    e.src = SW'(m_src);
    e.cnt = 16'(m_cnt);
    sbq.push_back(e);
  endtask

  // Called 1 time unit after a rising edge; returns 1 unit after the next one.
  task automatic drive(input logic [NREQ-1:0] r, input logic [2*NREQ-1:0] o,
                       input logic [IW*NREQ-1:0] x, input logic ec);
    bus.req = r; bus.op = o; bus.idx = x; bus.err_clr = ec;
    model_step(r, o, x, ec);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    drive('0, '0, '0, 1'b0);
  endtask

  function automatic logic [2*NREQ-1:0] ops(input logic [1:0] o0, o1, o2, o3);
    return {o3, o2, o1, o0};
  endfunction

  function automatic logic [IW*NREQ-1:0] idxs(input logic [IW-1:0] i0, i1, i2, i3);
    return {i3, i2, i1, i0};
  endfunction

  task automatic release_reset();
    bus.req = '0; bus.op = '0; bus.idx = '0; bus.err_clr = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    release_reset();
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    logic [NFLAG-1:0] qb;
    if (rst_n && bus.gnt !== '0) begin
      if (sbq.size() == 0) begin
        chk("unexpected_gnt", 32'(bus.gnt), 32'h0);
      end else begin
        e  = sbq.pop_front();
        qb = ~e.q;
        chk("gnt",     32'(bus.gnt),     32'(e.gnt));
        chk("q",       32'(bus.q),       32'(e.q));
        chk("qbar",    32'(bus.qbar),    32'(qb));
        chk("err",     32'(bus.err),     32'(e.err));
        chk("err_src", 32'(bus.err_src), 32'(e.src));
        chk("op_cnt",  32'(bus.op_cnt),  32'(e.cnt));
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [2*NREQ-1:0]  o;
    logic [IW*NREQ-1:0] x;
    model_reset();
    bus.req = '0; bus.op = '0; bus.idx = '0; bus.err_clr = 1'b0;

    // Reset held: outputs pinned regardless of input activity
    for (int i = 0; i < 5; i++) begin
      bus.req = NREQ'($urandom); bus.op = 8'($urandom);
      bus.idx = 12'($urandom);   bus.err_clr = 1'($urandom);
      @(negedge clk);
      chk("rst_q",    32'(bus.q),      32'h0);
      chk("rst_qbar", 32'(bus.qbar),   32'h3F);
      chk("rst_gnt",  32'(bus.gnt),    32'h0);
      chk("rst_err",  32'(bus.err),    32'h0);
      chk("rst_cnt",  32'(bus.op_cnt), 32'h0);
    end
    release_reset();

    // Round-robin with all four requesting
    begin
      logic [NREQ-1:0] order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      for (int i = 0; i < 5; i++) begin
        drive(4'b1111, ops(2'b10, 2'b10, 2'b10, 2'b10), idxs(3'd0, 3'd1, 3'd2, 3'd3), 1'b0);
        chk("rr_order", 32'(bus.gnt), 32'(order[i]));
      end
      chk("rr_q", 32'(bus.q), 32'h0F);
    end
    idle();
    do_reset();

    // Single set then reset of flag 5
    drive(4'b0001, ops(2'b10, 2'b00, 2'b00, 2'b00), idxs(3'd5, 3'd0, 3'd0, 3'd0), 1'b0);
    chk("set_gnt", 32'(bus.gnt), 32'h1);
    chk("set_q",   32'(bus.q),   32'h20);
    drive(4'b0001, ops(2'b01, 2'b00, 2'b00, 2'b00), idxs(3'd5, 3'd0, 3'd0, 3'd0), 1'b0);
    drive(4'b0001, ops(2'b01, 2'b00, 2'b00, 2'b00), idxs(3'd5, 3'd0, 3'd0, 3'd0), 1'b0);
    idle();
    chk("rst5_q",   32'(bus.q),      32'h0);
    chk("rst5_cnt", 32'(bus.op_cnt), 32'h2);

    // Illegal command from requester 2, then clear
    drive(4'b0100, ops(2'b00, 2'b00, 2'b11, 2'b00), idxs(3'd0, 3'd0, 3'd1, 3'd0), 1'b0);
    chk("ill_gnt", 32'(bus.gnt),     32'h4);
    chk("ill_err", 32'(bus.err),     32'h1);
    chk("ill_src", 32'(bus.err_src), 32'h2);
    chk("ill_cnt", 32'(bus.op_cnt),  32'h2);
    chk("ill_q",   32'(bus.q),       32'h0);
    drive('0, '0, '0, 1'b1);
    chk("clr_err", 32'(bus.err), 32'h0);

    // Error from 3, then a new error from 1 racing err_clr
    drive(4'b1000, ops(2'b00, 2'b00, 2'b00, 2'b11), '0, 1'b0);
    idle();
    chk("race_pre_src", 32'(bus.err_src), 32'h3);
    drive(4'b0010, ops(2'b00, 2'b11, 2'b00, 2'b00), '0, 1'b1);
    chk("race_err", 32'(bus.err),     32'h1);
    chk("race_src", 32'(bus.err_src), 32'h1);
    idle();

    // Out-of-range index behaves like an illegal command
    drive(4'b0001, ops(2'b10, 2'b00, 2'b00, 2'b00), idxs(3'd7, 3'd0, 3'd0, 3'd0), 1'b1);
    chk("oor_err", 32'(bus.err),     32'h1);
    chk("oor_src", 32'(bus.err_src), 32'h0);
    chk("oor_q",   32'(bus.q),       32'h0);
    drive('0, '0, '0, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      drive(NREQ'($urandom), 8'($urandom), 12'($urandom), ($urandom_range(0, 7) == 0));
    end

    // Drive op_cnt to 0xFFFE with legal traffic, then three more commits
    while (m_cnt < 16'hFFFE) begin
      for (int r = 0; r < NREQ; r++) begin
        o[2*r +: 2]   = 2'($urandom_range(0, 2));
        x[IW*r +: IW] = IW'($urandom_range(0, NFLAG - 1));
      end
      drive(4'b1111, o, x, 1'b0);
    end
    chk("pre_sat_cnt", 32'(bus.op_cnt), 32'hFFFE);
    for (int i = 0; i < 3; i++) begin
      drive(4'b1111, ops(2'b10, 2'b10, 2'b10, 2'b10), idxs(3'd0, 3'd1, 3'd2, 3'd3), 1'b0);
    end
    chk("sat_cnt", 32'(bus.op_cnt), 32'hFFFF);

    // Reset mid-operation with a request pending and gnt high
    @(negedge clk); #1;
    bus.req = 4'b1111;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_gnt",  32'(bus.gnt),    32'h0);
    chk("midrst_q",    32'(bus.q),      32'h0);
    chk("midrst_qbar", 32'(bus.qbar),   32'h3F);
    chk("midrst_cnt",  32'(bus.op_cnt), 32'h0);
    chk("midrst_err",  32'(bus.err),    32'h0);
    repeat (2) @(posedge clk);
    release_reset();

    for (int i = 0; i < 50; i++) begin
      drive(NREQ'($urandom), 8'($urandom), 12'($urandom), ($urandom_range(0, 7) == 0));
    end
    repeat (3) idle();
    @(negedge clk); #1;
    chk("sb_drained", 32'(sbq.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
